// File: rtl/ram_master_pkg.sv
// Shared types and constants for the ram_master initiator.
package ram_master_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  // Wide enough for RD_LAT values 0..3.
  localparam int LAT_W = 2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    READ_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/ram_master.sv
// Command/response front end for the single-port synchronous RAM, with an
// optional post-reset fill of every location.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                RD_LAT  = 1,
  parameter int                INIT_EN = 1,
  parameter logic [DATA_W-1:0] FILL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int               DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  FILL_END  = (ADDR_W + 1)'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_END   = LAT_W'(RD_LAT);
  localparam state_t           RST_STATE = (INIT_EN != 0) ? INIT : IDLE;

  state_t            state, state_n;
  logic [ADDR_W:0]   fill_cnt, fill_n;
  logic [LAT_W-1:0]  lat_cnt, lat_n;
  logic              cmd_ready_n, rsp_valid_n, init_done_n, ram_wr_n;
  logic [DATA_W-1:0] rsp_data_n, ram_wr_data_n;
  logic [ADDR_W-1:0] ram_addr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RST_STATE;
      fill_cnt    <= '0;
      lat_cnt     <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      init_done   <= 1'b0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      state       <= state_n;
      fill_cnt    <= fill_n;
      lat_cnt     <= lat_n;
      cmd_ready   <= cmd_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_data    <= rsp_data_n;
      init_done   <= init_done_n;
      ram_wr      <= ram_wr_n;
      ram_addr    <= ram_addr_n;
      ram_wr_data <= ram_wr_data_n;
    end
  end

  // Every output is a register, so each branch computes the value the
  // outputs must show during the state being entered.
  always_comb begin
    state_n       = state;
    fill_n        = fill_cnt;
    lat_n         = lat_cnt;
    cmd_ready_n   = cmd_ready;
    rsp_valid_n   = rsp_valid;
    rsp_data_n    = rsp_data;
    init_done_n   = init_done;
    ram_wr_n      = 1'b0;
    ram_addr_n    = ram_addr;
    ram_wr_data_n = ram_wr_data;

    case (state)
      INIT: begin
        cmd_ready_n = 1'b0;
        if (fill_cnt == FILL_END) begin
          init_done_n = 1'b1;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end else begin
          ram_wr_n      = 1'b1;
          ram_addr_n    = fill_cnt[ADDR_W-1:0];
          ram_wr_data_n = FILL;
          fill_n        = fill_cnt + 1'b1;
        end
      end

      IDLE: begin
        init_done_n = 1'b1;
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          ram_addr_n  = cmd_addr;
          if (cmd_wr) begin
            ram_wr_n      = 1'b1;
            ram_wr_data_n = cmd_wdata;
            state_n       = WRITE;
          end else begin
            lat_n   = '0;
            state_n = READ_WAIT;
          end
        end
      end

      WRITE: begin
        cmd_ready_n = 1'b1;
        state_n     = IDLE;
      end

      // Address has been on the bus since the first READ_WAIT cycle, so the
      // sample lands RD_LAT cycles after that.
      READ_WAIT: begin
        if (lat_cnt == LAT_END) begin
          rsp_valid_n = 1'b1;
          rsp_data_n  = ram_rd_data;
          state_n     = RESP;
        end else begin
          lat_n = lat_cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end

      default: state_n = RST_STATE;
    endcase
  end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench: ram_master with a registered-read RAM (defaults) and a
// second instance with no fill and a combinational-read RAM.
module tb_ram_master;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: defaults, registered-read RAM.
  logic       rst = 1'b1, cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, init_done, ram_wr;
  logic [7:0] rsp_data, ram_wr_data, ram_rd_data;
  logic [2:0] ram_addr;
  logic [7:0] mem [8];

  ram_master #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1), .INIT_EN(1), .FILL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end

  // Instance B: no fill, combinational-read RAM.
  logic       rst0 = 1'b1, cmd_valid0 = 1'b0, cmd_wr0 = 1'b0, rsp_ready0 = 1'b0;
  logic [2:0] cmd_addr0 = '0;
  logic [7:0] cmd_wdata0 = '0;
  logic       cmd_ready0, rsp_valid0, init_done0, ram_wr0;
  logic [7:0] rsp_data0, ram_wr_data0, ram_rd_data0;
  logic [2:0] ram_addr0;
  logic [7:0] mem0 [8];

  ram_master #(.DATA_W(8), .ADDR_W(3), .RD_LAT(0), .INIT_EN(0), .FILL(8'h00)) dut0 (
    .clk(clk), .rst(rst0),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_wr(cmd_wr0),
    .cmd_addr(cmd_addr0), .cmd_wdata(cmd_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
    .init_done(init_done0),
    .ram_wr(ram_wr0), .ram_addr(ram_addr0), .ram_wr_data(ram_wr_data0),
    .ram_rd_data(ram_rd_data0)
  );

  always @(posedge clk) if (ram_wr0) mem0[ram_addr0] <= ram_wr_data0;
  assign ram_rd_data0 = mem0[ram_addr0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge right after reset release on instance A.
  task automatic check_fill();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("fill_wr%0d", i), ram_wr, 1);
      chk($sformatf("fill_addr%0d", i), ram_addr, i);
      chk($sformatf("fill_data%0d", i), ram_wr_data, 8'h00);
      chk($sformatf("fill_rdy%0d", i), {rsp_valid, cmd_ready, init_done}, 3'b000);
    end
    @(negedge clk);
    chk("fill_end_wr", ram_wr, 0);
    chk("fill_end_done", init_done, 1);
    chk("fill_end_ready", cmd_ready, 1);
  endtask

  task automatic issue(input logic wr, input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr_op(input logic [2:0] a, input logic [7:0] d);
    issue(1'b1, a, d);
    chk("wr_pulse", ram_wr, 1);
    chk("wr_addr", ram_addr, a);
    chk("wr_data", ram_wr_data, d);
    chk("wr_busy", cmd_ready, 0);
    @(negedge clk);
    chk("wr_end", ram_wr, 0);
    chk("wr_back_idle", cmd_ready, 1);
  endtask

  task automatic rd_op(input logic [2:0] a, input logic [7:0] exp);
    int n = 0;
    issue(1'b0, a, 8'h00);
    chk("rd_addr", ram_addr, a);
    chk("rd_no_wr", ram_wr, 0);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, 2);
    chk("rd_data", rsp_data, exp);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rd_rsp_drop", rsp_valid, 0);
    chk("rd_back_idle", cmd_ready, 1);
  endtask

  initial begin
    int n;
    // 1: reset state and fill sequence
    repeat (2) @(negedge clk);
    chk("rst_outs", {ram_wr, cmd_ready, rsp_valid, init_done}, 4'b0000);
    chk("rst_addr", ram_addr, 0);
    chk("rst0_outs", {init_done0, cmd_ready0}, 2'b00);
    rst = 1'b0;
    check_fill();

    // 2: write then read back
    wr_op(3'd0, 8'hCC);
    rd_op(3'd0, 8'hCC);

    // 3: overwrite, and a location only touched by the fill
    wr_op(3'd1, 8'hA5);
    wr_op(3'd1, 8'h00);
    rd_op(3'd1, 8'h00);
    rd_op(3'd7, 8'h00);

    // 4: response back-pressure with a command waiting
    issue(1'b0, 3'd0, 8'h00);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_arrive", rsp_valid, 1);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd2; cmd_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i), rsp_valid, 1);
      chk($sformatf("bp_data%0d", i), rsp_data, 8'hCC);
      chk($sformatf("bp_ready%0d", i), cmd_ready, 0);
      chk($sformatf("bp_nowr%0d", i), ram_wr, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", rsp_valid, 0);
    chk("bp_idle_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_acc_wr", ram_wr, 1);
    chk("bp_acc_addr", ram_addr, 3'd2);
    chk("bp_acc_data", ram_wr_data, 8'h77);
    @(negedge clk);
    chk("bp_acc_end", ram_wr, 0);

    // 5: reset during READ_WAIT
    issue(1'b0, 3'd0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ctl", {ram_wr, cmd_ready, rsp_valid, init_done}, 4'b0000);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_wdata", ram_wr_data, 0);
    chk("mid_rst_rdata", rsp_data, 0);
    check_fill();
    rd_op(3'd0, 8'h00);
    rd_op(3'd2, 8'h00);

    // 6: no fill, combinational read
    rst0 = 1'b0;
    @(negedge clk);
    chk("b_init_done", init_done0, 1);
    chk("b_ready", cmd_ready0, 1);
    chk("b_no_fill", ram_wr0, 0);
    cmd_valid0 = 1'b1; cmd_wr0 = 1'b1; cmd_addr0 = 3'd7; cmd_wdata0 = 8'h3C;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    chk("b_wr", ram_wr0, 1);
    chk("b_wr_addr", ram_addr0, 3'd7);
    chk("b_wr_data", ram_wr_data0, 8'h3C);
    @(negedge clk);
    chk("b_wr_end", {ram_wr0, cmd_ready0}, 2'b01);
    cmd_valid0 = 1'b1; cmd_wr0 = 1'b0; cmd_addr0 = 3'd7;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    chk("b_rd_wait", rsp_valid0, 0);
    @(negedge clk);
    chk("b_rd_valid", rsp_valid0, 1);
    chk("b_rd_data", rsp_data0, 8'h3C);
    rsp_ready0 = 1'b1;
    @(negedge clk);
    rsp_ready0 = 1'b0;
    chk("b_rsp_drop", rsp_valid0, 0);
    chk("b_back_idle", cmd_ready0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
